// File: rtl/muldiv_unit.sv
// muldiv_unit: 16-bit multi-cycle multiply/divide unit driving the HI/LO register pair.
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they execute as MULTU/DIVU.
module muldiv_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             wehilo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             divzero
);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   state_t state;
   logic [3:0] cnt;
   logic is_div, dz;
   logic [WIDTH-1:0] m, rem, ma, mb, quo, rmd;
   logic [2*WIDTH-1:0] acc, prod;
   logic [WIDTH:0] sum, t, diff;
`ifdef MULDIV_SIGNED_EN
   logic neg, neg_r, sa, sb;
   assign sa = ~op[0] & a[WIDTH-1];
   assign sb = ~op[0] & b[WIDTH-1];
   assign ma = sa ? -a : a;
   assign mb = sb ? -b : b;
   assign prod = neg ? -acc : acc;
   assign quo = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rmd = neg_r ? -rem : rem;
   always_ff @(posedge clk)
      if (state == IDLE && start) begin
         neg <= sa ^ sb;
         neg_r <= sa;
      end
`else
   logic unused_op;
   assign unused_op = op[0];
   assign ma = a;
   assign mb = b;
   assign prod = acc;
   assign quo = acc[WIDTH-1:0];
   assign rmd = rem;
`endif
   // multiply: add multiplicand into the upper half, then shift the whole accumulator right
   assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? m : '0};
   // divide: partial remainder is bounded by the divisor, so diff[WIDTH] is a pure borrow flag
   assign t = {rem, acc[WIDTH-1]};
   assign diff = t - {1'b0, m};
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy <= 1'b0;
         wehilo <= 1'b0;
         divzero <= 1'b0;
         hi <= '0;
         lo <= '0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               is_div <= op[1];
               dz <= op[1] & ~|b;
               m <= op[1] ? mb : ma;
               acc <= {{WIDTH{1'b0}}, op[1] ? ma : mb};
               rem <= '0;
               cnt <= '0;
               busy <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               if (is_div) begin
                  rem <= diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0];
                  acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~diff[WIDTH]};
               end else
                  acc <= {sum, acc[WIDTH-1:1]};
               cnt <= cnt + 4'd1;
               if (cnt == 4'(WIDTH-1)) state <= FIX;
            end
            FIX: begin
               hi <= is_div ? rmd : prod[2*WIDTH-1:WIDTH];
               lo <= is_div ? (dz ? '1 : quo) : prod[WIDTH-1:0];
               wehilo <= 1'b1;
               divzero <= dz;
               state <= DONE;
            end
            DONE: begin
               wehilo <= 1'b0;
               divzero <= 1'b0;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
`ifdef MULDIV_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [1:0] op = 2'b00;
   logic [15:0] a = '0, b = '0;
   logic busy, wehilo, divzero;
   logic [15:0] hi, lo;
   int total = 0, bad = 0;

   muldiv_unit #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .wehilo(wehilo), .hi(hi), .lo(lo), .divzero(divzero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                 output logic [15:0] eh, output logic [15:0] el, output logic ed);
      longint xs, ys, p, q, r;
      if (SGN && !o[0]) begin
         xs = longint'($signed(x));
         ys = longint'($signed(y));
      end else begin
         xs = longint'(x);
         ys = longint'(y);
      end
      ed = 1'b0;
      if (!o[1]) begin
         p = xs * ys;
         eh = p[31:16];
         el = p[15:0];
      end else if (y == 16'h0) begin
         ed = 1'b1;
         eh = x;
         el = 16'hFFFF;
      end else begin
         q = xs / ys;
         r = xs % ys;
         eh = r[15:0];
         el = q[15:0];
      end
   endfunction

   task automatic run(input string tag, input logic [1:0] o, input logic [15:0] x,
                      input logic [15:0] y, input bit ghost);
      int busy_n = 0, we_n = 0, we_k = 0, dz_stray = 0;
      logic [15:0] h = '0, l = '0, eh, el;
      logic d = 1'b0, ed;
      model(o, x, y, eh, el, ed);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         start = ghost && (k == 5 || k == 10);
         if (start) begin
            op = 2'(k);
            a = 16'($urandom);
            b = 16'($urandom);
         end
         if (busy) busy_n++;
         if (wehilo) begin
            we_n++;
            we_k = k;
            h = hi;
            l = lo;
            d = divzero;
         end else if (divzero) dz_stray++;
      end
      check({tag, ".busy_cycles"}, busy_n, 18);
      check({tag, ".we_pulses"}, we_n, 1);
      check({tag, ".we_cycle"}, we_k, 18);
      check({tag, ".hi"}, h, eh);
      check({tag, ".lo"}, l, el);
      check({tag, ".divzero"}, d, ed);
      check({tag, ".dz_stray"}, dz_stray, 0);
   endtask

   initial begin
      int we_n;
      repeat (3) @(negedge clk);
      check("rst.busy", busy, 0);
      check("rst.wehilo", wehilo, 0);
      check("rst.divzero", divzero, 0);
      check("rst.hi", hi, 0);
      check("rst.lo", lo, 0);
      start = 1'b1; op = 2'b01; a = 16'd3; b = 16'd4;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rst_vs_start.busy", busy, 0);
      run("multu_max", 2'b01, 16'hFFFF, 16'hFFFF, 1'b0);
      run("mult_neg", 2'b00, 16'hFFFD, 16'h0005, 1'b0);
      run("mult_min", 2'b00, 16'h8000, 16'h8000, 1'b0);
      run("divu", 2'b11, 16'd100, 16'd7, 1'b0);
      run("div_neg", 2'b10, 16'hFFF9, 16'h0002, 1'b0);
      run("div_ovf", 2'b10, 16'h8000, 16'hFFFF, 1'b0);
      run("div_zero", 2'b10, 16'h1234, 16'h0000, 1'b0);
      run("divu_zero", 2'b11, 16'hBEEF, 16'h0000, 1'b0);
      run("ghost", 2'b01, 16'd3, 16'd4, 1'b1);
      run("pre_abort", 2'b01, 16'h1234, 16'h5678, 1'b0);
      @(negedge clk);
      start = 1'b1; op = 2'b11; a = 16'd100; b = 16'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort.busy", busy, 0);
      check("abort.hi", hi, 0);
      check("abort.lo", lo, 0);
      check("abort.wehilo", wehilo, 0);
      reset = 1'b0;
      we_n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (wehilo || busy) we_n++;
      end
      check("abort.no_activity", we_n, 0);
      run("after_abort", 2'b11, 16'd100, 16'd7, 1'b0);
      for (int i = 0; i < 40; i++) begin
         logic [15:0] x, y;
         x = 16'($urandom);
         y = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
         if (i % 10 == 3) x = 16'h8000;
         if (i % 10 == 7) y = 16'hFFFF;
         run($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), x, y, i % 5 == 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
